// File: rtl/lcd_client_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : lcd_client_arbiter
//  Description : Round-robin arbiter sharing one SPI LCD between three clients
//                with grant timeout and an idle gap between grants.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_client_arbiter #(
    parameter logic [31:0] TIMEOUT    = 32'd5_400_000,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [2:0] i_req,
    input  logic [2:0] i_mosi,
    input  logic [2:0] i_dc,
    input  logic [2:0] i_cs,
    input  logic [2:0] i_done,
    output logic [2:0] o_start,
    output logic [2:0] o_grant,
    output logic       o_mosi,
    output logic       o_dc,
    output logic       o_cs,
    output logic       o_busy,
    output logic       o_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [31:0] c_timeout_last = TIMEOUT - 32'd1;
    localparam logic [7:0]  c_gap_last     = 8'(GAP_CYCLES - 1);

    state_t      r_state;
    logic [2:0]  r_grant;
    logic [2:0]  r_start;
    logic        r_timeout;
    logic [1:0]  r_owner;
    logic [1:0]  r_last_owner;
    logic [31:0] r_wait_cnt;
    logic [7:0]  r_gap_cnt;

    logic [1:0]  w_winner;
    logic [2:0]  w_winner_oh;
    logic        w_owner_done;

    // Search starts one past the previous owner so a persistent requester
    // cannot be served twice while another client is waiting.
    always_comb begin
        w_winner = 2'd0;
        case (r_last_owner)
            2'd0: begin
                if (i_req[1])      w_winner = 2'd1;
                else if (i_req[2]) w_winner = 2'd2;
                else               w_winner = 2'd0;
            end
            2'd1: begin
                if (i_req[2])      w_winner = 2'd2;
                else if (i_req[0]) w_winner = 2'd0;
                else               w_winner = 2'd1;
            end
            default: begin
                if (i_req[0])      w_winner = 2'd0;
                else if (i_req[1]) w_winner = 2'd1;
                else               w_winner = 2'd2;
            end
        endcase
    end

    assign w_winner_oh  = 3'b001 << w_winner;
    assign w_owner_done = |(i_done & r_grant);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= 3'b000;
            r_start      <= 3'b000;
            r_timeout    <= 1'b0;
            r_owner      <= 2'd0;
            r_last_owner <= 2'd2;
            r_wait_cnt   <= 32'd0;
            r_gap_cnt    <= 8'd0;
        end else begin
            r_start   <= 3'b000;
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|i_req) begin
                        r_grant <= w_winner_oh;
                        r_start <= w_winner_oh;
                        r_owner <= w_winner;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    r_wait_cnt <= 32'd0;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 32'd1;
                    // Completion has priority over a coincident timeout.
                    if (w_owner_done || (r_wait_cnt == c_timeout_last)) begin
                        r_timeout    <= ~w_owner_done;
                        r_grant      <= 3'b000;
                        r_last_owner <= r_owner;
                        r_gap_cnt    <= 8'd0;
                        r_state      <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == c_gap_last) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Shared bus idles with chip select released when nobody owns it.
    always_comb begin
        o_mosi = 1'b0;
        o_dc   = 1'b0;
        o_cs   = 1'b1;
        case (r_grant)
            3'b001: begin
                o_mosi = i_mosi[0];
                o_dc   = i_dc[0];
                o_cs   = i_cs[0];
            end
            3'b010: begin
                o_mosi = i_mosi[1];
                o_dc   = i_dc[1];
                o_cs   = i_cs[1];
            end
            3'b100: begin
                o_mosi = i_mosi[2];
                o_dc   = i_dc[2];
                o_cs   = i_cs[2];
            end
            default: begin
                o_mosi = 1'b0;
                o_dc   = 1'b0;
                o_cs   = 1'b1;
            end
        endcase
    end

    assign o_start   = r_start;
    assign o_grant   = r_grant;
    assign o_timeout = r_timeout;
    assign o_busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/lcd_client_arbiter.md
LCD_CLIENT_ARBITER -- requirements
Module: lcd_client_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 32'd5_400_000, meaning max WAIT cycles before a grant is forcibly revoked.
REQ-002 SHALL have parameter GAP_CYCLES, default 4, meaning idle cycles (cs high) between consecutive grants; legal range 1..255.
REQ-003 i_clk  input  1  clock; all logic on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_req  input  3  per-client transaction request, level.
REQ-006 i_mosi  input  3  per-client SPI data line.
REQ-007 i_dc  input  3  per-client data/command select.
REQ-008 i_cs  input  3  per-client chip select, active-low.
REQ-009 i_done  input  3  per-client one-cycle completion pulse.
REQ-010 o_start  output  3  one-hot one-cycle start pulse to the granted client.
REQ-011 o_grant  output  3  one-hot current owner; 3'b000 when none.
REQ-012 o_mosi, o_dc, o_cs  output  1 each  shared LCD SPI lines.
REQ-013 o_busy  output  1  high whenever state is not IDLE.
REQ-014 o_timeout  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-015 SHALL implement FSM states IDLE, START, WAIT, GAP, all registered.
REQ-016 IDLE: if i_req != 0, SHALL select the winner round-robin starting at (last_owner+1) mod 3, register o_grant one-hot, and go to START; otherwise stay.
REQ-017 START: SHALL last exactly one cycle, drive o_start = o_grant, then go to WAIT with the timeout counter cleared.
REQ-018 WAIT: SHALL increment a 32-bit counter each cycle; on i_done[owner]=1, go to GAP; else when counter == TIMEOUT-1, pulse o_timeout and go to GAP.
REQ-019 i_done simultaneous with the timeout condition SHALL count as normal completion (no o_timeout).
REQ-020 i_done from non-owner clients SHALL be ignored in all states; i_done[owner] during START SHALL be ignored.
REQ-021 Deassertion of i_req[owner] during START/WAIT SHALL NOT end the grant; only done or timeout ends it.
REQ-022 On entry to GAP, SHALL clear o_grant, set last_owner to the departing owner, and hold GAP for GAP_CYCLES cycles, then go to IDLE.
REQ-023 Owner latency: request seen in IDLE at edge N -> o_grant and o_start valid in cycle N+1; minimum spacing between o_start pulses = GAP_CYCLES + 3 cycles.
REQ-024 o_mosi/o_dc/o_cs SHALL be combinational muxes of i_mosi/i_dc/i_cs indexed by o_grant; with o_grant == 0 they SHALL be 0/0/1.
REQ-025 Only one o_grant and one o_start bit SHALL ever be high at once.
REQ-026 A requester that holds i_req continuously SHALL be granted at most once before every other continuously-requesting client is granted once.

Reset
REQ-027 i_rst SHALL immediately force state IDLE, o_grant=0, o_start=0, o_timeout=0, o_busy=0, o_mosi=0, o_dc=0, o_cs=1, counters=0, last_owner=2 (client 0 has first priority).
REQ-028 Reset asserted mid-WAIT SHALL abandon the transaction with no o_timeout pulse; the first post-reset grant follows REQ-016 with last_owner=2.

Verification
REQ-029 Single request: i_req=3'b010 held, client pulses i_done 100 cycles after o_start -> o_grant=3'b010 one cycle after request, o_start=3'b010 for 1 cycle, o_cs follows i_cs[1], o_grant=0 and o_cs=1 for 4 GAP cycles, o_timeout never high.
REQ-030 Round-robin fairness: i_req=3'b111 held, each client completes after 10 cycles -> grant order 0,1,2,0,1,2; o_start pulses spaced 10+GAP_CYCLES+3 cycles apart.
REQ-031 Timeout: TIMEOUT=50, i_req=3'b001, no i_done -> o_timeout pulses exactly 50 cycles after START exits, grant released, client 0 re-granted after GAP.
REQ-032 Done/timeout collision: TIMEOUT=50, i_done[owner] on the 50th WAIT cycle -> no o_timeout, normal GAP.
REQ-033 Spurious signals: during owner 1 WAIT, pulse i_done[0], toggle i_cs[2], drop i_req[1] -> grant unchanged, outputs track client 1 only until its i_done.
REQ-034 Reset mid-op: assert i_rst during WAIT of owner 2 with i_req=3'b111 -> outputs take reset values in the same cycle; after release client 0 is granted first.
